// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing source for the display path.
//
// Produces the DrawX/DrawY/blank scan interface that the renderers consume,
// plus hs/vs for the VGA DAC. hs/vs pass through a SYNC_DELAY-deep delay line
// advanced by pix_en, so sync stays aligned with the renderers' registered
// colour outputs.
//
// Ports:
//   vga_clk      in   pixel-domain clock
//   reset_n      in   synchronous active-low reset (overrides pix_en)
//   pix_en       in   pixel advance qualifier (tie 1 for a 25 MHz vga_clk)
//   DrawX        out  horizontal counter, 0..H_TOTAL-1
//   DrawY        out  vertical counter, 0..V_TOTAL-1
//   blank        out  1 = DrawX/DrawY inside the active area
//   hs, vs       out  sync, lagging DrawX/DrawY by SYNC_DELAY enabled pixels
//   line_start   out  1 while DrawX == 0
//   frame_start  out  1 while DrawX == 0 and DrawY == 0
//
// All outputs come straight from flops.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Stage 0 of each pipe is the raw sync registered with the counters; the
  // remaining SYNC_DELAY stages form the delay line.
  localparam int unsigned PipeW = SYNC_DELAY + 1;
  typedef logic [PipeW-1:0] pipe_t;

  // Boundaries are kept 11 bits wide so a sync end equal to 1024 still compares
  // correctly against the 10-bit counters.
  localparam logic [9:0]  HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast      = 10'(V_TOTAL - 1);
  localparam logic [10:0] HActEnd    = 11'(H_ACTIVE);
  localparam logic [10:0] VActEnd    = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam bit    SyncIdle = ~SYNC_POL;
  localparam pipe_t PipeIdle = {PipeW{SyncIdle}};

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  if (SYNC_DELAY > 7) begin : gen_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..7");
  end

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  pipe_t      hs_pipe_q, hs_pipe_d;
  pipe_t      vs_pipe_q, vs_pipe_d;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        hs_raw;
  logic        vs_raw;

  // Next-state: counters advance and every flag/sync stage is reloaded only
  // on enabled pixels; otherwise everything holds.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    blank_d       = blank_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;

    if (pix_en) begin
      if (x_q == HLast) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Flags and raw sync describe the counter values being loaded, so they
    // land in the same cycle as the DrawX/DrawY they refer to.
    x_ext  = {1'b0, x_d};
    y_ext  = {1'b0, y_d};
    hs_raw = (x_ext >= HSyncStart && x_ext < HSyncEnd) ? SYNC_POL : SyncIdle;
    vs_raw = (y_ext >= VSyncStart && y_ext < VSyncEnd) ? SYNC_POL : SyncIdle;

    if (pix_en) begin
      blank_d       = (x_ext < HActEnd) && (y_ext < VActEnd);
      line_start_d  = (x_d == 10'd0);
      frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
      // Shift in the new raw sample; the cast drops the oldest stage.
      hs_pipe_d     = pipe_t'({hs_pipe_q, hs_raw});
      vs_pipe_d     = pipe_t'({vs_pipe_q, vs_raw});
    end
  end

  // Reset parks the counters on the last pixel so the first enabled edge
  // lands on (0,0), and fills the whole delay line with the idle level so no
  // stale sync pulse can emerge after release.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_q           <= HLast;
      y_q           <= VLast;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= PipeIdle;
      vs_pipe_q     <= PipeIdle;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hs          = hs_pipe_q[PipeW-1];
  assign vs          = vs_pipe_q[PipeW-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic pix_en;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;  // enabled edges since the last reset edge

  // Default 640x480 timing, SYNC_DELAY = 2, active-low sync.
  logic [9:0] b_x, b_y;
  logic       b_blank, b_hs, b_vs, b_ls, b_fs;
  vga_timing_gen #(
    .SYNC_DELAY(2)
  ) u_big (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(b_x), .DrawY(b_y), .blank(b_blank), .hs(b_hs), .vs(b_vs),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // Small frame (31 x 17), SYNC_DELAY = 0, active-low sync.
  logic [9:0] s0_x, s0_y;
  logic       s0_blank, s0_hs, s0_vs, s0_ls, s0_fs;
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .SYNC_DELAY(0)
  ) u_s0 (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s0_x), .DrawY(s0_y), .blank(s0_blank), .hs(s0_hs), .vs(s0_vs),
    .line_start(s0_ls), .frame_start(s0_fs)
  );

  // Small frame (24 x 12), SYNC_DELAY = 3, active-high sync.
  logic [9:0] s3_x, s3_y;
  logic       s3_blank, s3_hs, s3_vs, s3_ls, s3_fs;
  vga_timing_gen #(
    .H_ACTIVE(12), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(3), .V_BP(2),
    .SYNC_POL(1'b1), .SYNC_DELAY(3)
  ) u_s3 (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s3_x), .DrawY(s3_y), .blank(s3_blank), .hs(s3_hs), .vs(s3_vs),
    .line_start(s3_ls), .frame_start(s3_fs)
  );

  typedef struct {
    int x;
    int y;
    bit blank;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
  } exp_t;

  // Reference: position is simply (enabled edges since reset - 1) along the
  // raster; sync is the raster rule applied dly pixels in the past.
  function automatic exp_t model(input int n, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb, input int dly, input bit pol);
    exp_t e;
    int ht, vt, p, q, qx, qy;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (n == 0) begin
      e.x = ht - 1; e.y = vt - 1;
      e.blank = 0; e.ls = 0; e.fs = 0;
      e.hs = ~pol; e.vs = ~pol;
    end else begin
      p = n - 1;
      e.x = p % ht;
      e.y = (p / ht) % vt;
      e.blank = (e.x < ha) && (e.y < va);
      e.ls = (e.x == 0);
      e.fs = (e.x == 0) && (e.y == 0);
      q = p - dly;
      if (q < 0) begin
        e.hs = ~pol; e.vs = ~pol;
      end else begin
        qx = q % ht;
        qy = (q / ht) % vt;
        e.hs = (qx >= ha + hf && qx < ha + hf + hsw) ? pol : ~pol;
        e.vs = (qy >= va + vf && qy < va + vf + vsw) ? pol : ~pol;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cnt=%0d)", tag, obs, exp, cnt);
    end
  endtask

  task automatic chk_inst(input string nm, input exp_t e, input logic [9:0] x,
                          input logic [9:0] y, input logic bl, input logic h, input logic v,
                          input logic ls, input logic fs);
    chk({nm, ".DrawX"}, {22'd0, x}, e.x);
    chk({nm, ".DrawY"}, {22'd0, y}, e.y);
    chk({nm, ".blank"}, {31'd0, bl}, {31'd0, e.blank});
    chk({nm, ".hs"}, {31'd0, h}, {31'd0, e.hs});
    chk({nm, ".vs"}, {31'd0, v}, {31'd0, e.vs});
    chk({nm, ".line_start"}, {31'd0, ls}, {31'd0, e.ls});
    chk({nm, ".frame_start"}, {31'd0, fs}, {31'd0, e.fs});
  endtask

  task automatic check_all();
    chk_inst("big", model(cnt, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0),
             b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs);
    chk_inst("s0", model(cnt, 16, 4, 6, 5, 10, 2, 2, 3, 0, 1'b0),
             s0_x, s0_y, s0_blank, s0_hs, s0_vs, s0_ls, s0_fs);
    chk_inst("s3", model(cnt, 12, 3, 5, 4, 6, 1, 3, 2, 3, 1'b1),
             s3_x, s3_y, s3_blank, s3_hs, s3_vs, s3_ls, s3_fs);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit rn, input bit en);
    @(negedge clk);
    reset_n = rn;
    pix_en  = en;
    @(posedge clk);
    if (!rn) cnt = 0;
    else if (en) cnt++;
    #1;
    check_all();
  endtask

  initial begin
    int found;
    reset_n = 1'b0;
    pix_en  = 1'b0;

    // Reset with pix_en wandering: reset must win.
    for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2));
    chk("rst.DrawX", {22'd0, b_x}, 799);
    chk("rst.DrawY", {22'd0, b_y}, 524);
    chk("rst.hs", {31'd0, b_hs}, 1);
    chk("rst.vs", {31'd0, b_vs}, 1);

    // First enabled edge lands on (0,0) with all start flags.
    step(1'b1, 1'b1);
    chk("first.DrawX", {22'd0, b_x}, 0);
    chk("first.DrawY", {22'd0, b_y}, 0);
    chk("first.blank", {31'd0, b_blank}, 1);
    chk("first.frame_start", {31'd0, b_fs}, 1);

    // Two full lines at full rate; spot-check the delayed hs edges.
    for (int i = 0; i < 1700; i++) begin
      step(1'b1, 1'b1);
      if (b_y == 10'd0 && b_x == 10'd657) chk("hs_still_high_657", {31'd0, b_hs}, 1);
      if (b_y == 10'd0 && b_x == 10'd658) chk("hs_low_658", {31'd0, b_hs}, 0);
      if (b_y == 10'd0 && b_x == 10'd753) chk("hs_low_753", {31'd0, b_hs}, 0);
      if (b_y == 10'd0 && b_x == 10'd754) chk("hs_high_754", {31'd0, b_hs}, 1);
    end

    // Randomly gated pix_en across several small frames.
    for (int i = 0; i < 3000; i++) step(1'b1, ($urandom_range(0, 9) < 7));

    // Alternate-cycle pix_en (50 MHz use).
    for (int i = 0; i < 600; i++) step(1'b1, 1'(i % 2));

    // Freeze for 10 cycles mid-line.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

    // Run s0 into an active hs and vs, then reset there.
    found = 0;
    for (int i = 0; i < 1200 && found == 0; i++) begin
      step(1'b1, 1'b1);
      if (s0_x == 10'd22 && s0_y == 10'd13) found = 1;
    end
    chk("s0.found_sync_point", found, 1);
    chk("s0.hs_active_pre", {31'd0, s0_hs}, 0);
    chk("s0.vs_active_pre", {31'd0, s0_vs}, 0);
    step(1'b0, 1'b1);
    chk("midrst.hs", {31'd0, s0_hs}, 1);
    chk("midrst.vs", {31'd0, s0_vs}, 1);
    chk("midrst.DrawX", {22'd0, s0_x}, 30);
    chk("midrst.DrawY", {22'd0, s0_y}, 16);
    for (int i = 0; i < 1200; i++) step(1'b1, ($urandom_range(0, 9) < 8));

    // Random stimulus with occasional reset pulses.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 249) != 0), ($urandom_range(0, 9) < 7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
